writeback_stage: RTL

//  Final pipeline stage: MEM/WB register plus result selection and load-data

---
 rtl/writeback_stage.sv | 125 ++++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Final pipeline stage: MEM/WB register, result select, load alignment/extension,
// misaligned-load detection and retired-instruction counter.
module writeback_stage #(
    parameter int unsigned CNT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             mem_valid,
    input  logic             mem_reg_write,
    input  logic             mem_to_reg,
    input  logic             mem_jump,
    input  logic [4:0]       mem_rd,
    input  logic [2:0]       mem_funct3,
    input  logic [31:0]      mem_alu_result,
    input  logic [31:0]      mem_rdata,
    input  logic [31:0]      mem_pc_plus4,
    output logic             RegWrite_WB,
    output logic [4:0]       reg_write_addr,
    output logic [31:0]      reg_write_data,
    output logic             load_misaligned,
    output logic [CNT_W-1:0] instret
);

    localparam logic [2:0] F3Lb  = 3'b000;
    localparam logic [2:0] F3Lh  = 3'b001;
    localparam logic [2:0] F3Lw  = 3'b010;
    localparam logic [2:0] F3Lbu = 3'b100;
    localparam logic [2:0] F3Lhu = 3'b101;

    logic             r_valid;
    logic             r_reg_write;
    logic             r_mem_to_reg;
    logic             r_jump;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic [31:0]      r_alu;
    logic [31:0]      r_rdata;
    logic [31:0]      r_pc_plus4;
    logic [CNT_W-1:0] r_instret;

    logic [1:0]  w_off;
    logic [31:0] w_byte_shift;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic [31:0] w_result;
    logic        w_misaligned;
    logic        w_retire;

    // MEM/WB pipe register; flush overrides mem_valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid      <= 1'b0;
            r_reg_write  <= 1'b0;
            r_mem_to_reg <= 1'b0;
            r_jump       <= 1'b0;
            r_rd         <= 5'd0;
            r_funct3     <= 3'd0;
            r_alu        <= 32'd0;
            r_rdata      <= 32'd0;
            r_pc_plus4   <= 32'd0;
        end else begin
            r_valid      <= mem_valid & ~flush;
            r_reg_write  <= mem_reg_write;
            r_mem_to_reg <= mem_to_reg;
            r_jump       <= mem_jump;
            r_rd         <= mem_rd;
            r_funct3     <= mem_funct3;
            r_alu        <= mem_alu_result;
            r_rdata      <= mem_rdata;
            r_pc_plus4   <= mem_pc_plus4;
        end
    end

    // Load alignment/extension, misalignment detection and result select
    always_comb begin
        w_off        = r_alu[1:0];
        w_byte_shift = r_rdata >> {w_off, 3'b000};
        w_byte       = w_byte_shift[7:0];
        w_half       = w_off[1] ? r_rdata[31:16] : r_rdata[15:0];

        case (r_funct3)
            F3Lb:    w_load = {{24{w_byte[7]}}, w_byte};
            F3Lh:    w_load = {{16{w_half[15]}}, w_half};
            F3Lw:    w_load = r_rdata;
            F3Lbu:   w_load = {24'd0, w_byte};
            F3Lhu:   w_load = {16'd0, w_half};
            default: w_load = r_rdata;
        endcase

        w_misaligned = r_valid & r_mem_to_reg &
                       ((((r_funct3 == F3Lh) | (r_funct3 == F3Lhu)) & w_off[0]) |
                        ((r_funct3 == F3Lw) & (w_off != 2'd0)));

        if (r_jump) begin
            w_result = r_pc_plus4;
        end else if (r_mem_to_reg) begin
            w_result = w_load;
        end else begin
            w_result = r_alu;
        end

        w_retire = r_valid & ~w_misaligned;
    end

    // Retired-instruction counter; wraps naturally at 2^CNT_W
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instret <= '0;
        end else if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
        end
    end

    // Register-file write port, forced to zero when the entry is not valid
    always_comb begin
        RegWrite_WB     = r_valid & r_reg_write & (r_rd != 5'd0) & ~w_misaligned;
        reg_write_addr  = r_valid ? r_rd : 5'd0;
        reg_write_data  = r_valid ? w_result : 32'd0;
        load_misaligned = w_misaligned;
        instret         = r_instret;
    end

endmodule
